// File: rtl/simple_axi_arb_pkg.sv
// Shared types and helpers for the simple-AXI write arbiter.
package simple_axi_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A single-requester index still needs one bit to exist as a port.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/simple_axi_write_arbiter_rr_picker.sv
// Combinational requester picker: round-robin after last_owner, or fixed
// lowest-index priority when SIMPLE_AXI_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_owner,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
    logic w_last_owner_unused;
    assign w_last_owner_unused = ^i_last_owner;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end
`else
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W:0]       w_base;
    logic [IDX_W:0]       w_off;
    logic [IDX_W+1:0]     w_sum;

    // Bit j of w_rot is requester (last_owner + 1 + j) mod NUM_REQ.
    always_comb begin
        w_dbl   = {i_req, i_req};
        w_base  = {1'b0, i_last_owner} + (IDX_W+1)'(1);
        w_rot   = w_dbl[w_base +: NUM_REQ];
        w_off   = '0;
        o_valid = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_valid = 1'b1;
                w_off   = (IDX_W+1)'(j);
            end
        end
        w_sum = {1'b0, w_base} + {1'b0, w_off};
        if (w_sum >= (IDX_W+2)'(NUM_REQ)) w_sum = w_sum - (IDX_W+2)'(NUM_REQ);
        o_idx = w_sum[IDX_W-1:0];
    end
`endif

endmodule

// File: rtl/simple_axi_write_arbiter.sv
// Shares one simple-AXI write port among NUM_REQ requesters, holding each grant
// for a whole transfer. Build option: SIMPLE_AXI_ARB_FIXED_PRIO_EN (fixed priority).
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate among pending requests, bridge sees no valid
//   ST_GRANT | grant_idx_o owns the bridge until m_wlast_i
module simple_axi_write_arbiter
    import simple_axi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8,
    localparam int STRB_W    = AXI_DATA_W / 8,
    localparam int IDX_W     = idx_w(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_wvalid_i,
    output logic [NUM_REQ-1:0]            req_wready_o,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0] req_waddr_i,
    input  logic [NUM_REQ*AXI_DATA_W-1:0] req_wdata_i,
    input  logic [NUM_REQ*STRB_W-1:0]     req_wstrb_i,
    input  logic [NUM_REQ*LEN_W-1:0]      req_wlen_i,
    output logic [NUM_REQ-1:0]            req_wlast_o,
    output logic                          m_wvalid_o,
    input  logic                          m_wready_i,
    output logic [AXI_ADDR_W-1:0]         m_waddr_o,
    output logic [AXI_DATA_W-1:0]         m_wdata_o,
    output logic [STRB_W-1:0]             m_wstrb_o,
    output logic [LEN_W-1:0]              m_wlen_o,
    input  logic                          m_wlast_i,
    output logic                          busy_o,
    output logic [IDX_W-1:0]              grant_idx_o
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_last_owner;
    logic [IDX_W-1:0] w_last_owner_nxt;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req        (req_wvalid_i),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    // last_owner resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_owner_nxt = r_last_owner;
        m_wvalid_o       = 1'b0;
        m_waddr_o        = '0;
        m_wdata_o        = '0;
        m_wstrb_o        = '0;
        m_wlen_o         = '0;
        req_wready_o     = '0;
        req_wlast_o      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                m_wvalid_o            = req_wvalid_i[r_grant];
                m_waddr_o             = req_waddr_i[int'(r_grant)*AXI_ADDR_W +: AXI_ADDR_W];
                m_wdata_o             = req_wdata_i[int'(r_grant)*AXI_DATA_W +: AXI_DATA_W];
                m_wstrb_o             = req_wstrb_i[int'(r_grant)*STRB_W +: STRB_W];
                m_wlen_o              = req_wlen_i[int'(r_grant)*LEN_W +: LEN_W];
                req_wready_o[r_grant] = m_wready_i;
                req_wlast_o[r_grant]  = m_wlast_i;
                // Always pass through IDLE so the bridge can return to its start state.
                if (m_wlast_i) begin
                    w_last_owner_nxt = r_grant;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o      = (r_state == ST_GRANT);
    assign grant_idx_o = r_grant;

endmodule

// File: tb/tb_simple_axi_write_arbiter.sv
// Directed bench for simple_axi_write_arbiter with NUM_REQ=4, 32-bit address/data.
module tb_simple_axi_write_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int LW = 8;
    localparam int IW = 2;

`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
    localparam logic [IW-1:0] NEXT_AFTER_GAP = 2'd0;
`else
    localparam logic [IW-1:0] NEXT_AFTER_GAP = 2'd3;
`endif

    localparam logic [AW-1:0] ADDR [NR] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};
    localparam logic [DW-1:0] DATA [NR] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    localparam logic [SW-1:0] STRB [NR] = '{4'h1, 4'h3, 4'h7, 4'hF};
    localparam logic [LW-1:0] LEN  [NR] = '{8'd4, 8'd8, 8'd12, 8'd16};

    logic             clk_i;
    logic             rst_ni;
    logic [NR-1:0]    req_wvalid_i;
    logic [NR-1:0]    req_wready_o;
    logic [NR*AW-1:0] req_waddr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [NR*SW-1:0] req_wstrb_i;
    logic [NR*LW-1:0] req_wlen_i;
    logic [NR-1:0]    req_wlast_o;
    logic             m_wvalid_o;
    logic             m_wready_i;
    logic [AW-1:0]    m_waddr_o;
    logic [DW-1:0]    m_wdata_o;
    logic [SW-1:0]    m_wstrb_o;
    logic [LW-1:0]    m_wlen_o;
    logic             m_wlast_i;
    logic             busy_o;
    logic [IW-1:0]    grant_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    simple_axi_write_arbiter #(
        .NUM_REQ    (NR),
        .AXI_ADDR_W (AW),
        .AXI_DATA_W (DW),
        .LEN_W      (LW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_wvalid_i (req_wvalid_i),
        .req_wready_o (req_wready_o),
        .req_waddr_i  (req_waddr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wstrb_i  (req_wstrb_i),
        .req_wlen_i   (req_wlen_i),
        .req_wlast_o  (req_wlast_o),
        .m_wvalid_o   (m_wvalid_o),
        .m_wready_i   (m_wready_i),
        .m_waddr_o    (m_waddr_o),
        .m_wdata_o    (m_wdata_o),
        .m_wstrb_o    (m_wstrb_o),
        .m_wlen_o     (m_wlen_o),
        .m_wlast_i    (m_wlast_i),
        .busy_o       (busy_o),
        .grant_idx_o  (grant_idx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_payload();
        for (int k = 0; k < NR; k++) begin
            req_waddr_i[k*AW +: AW] = ADDR[k];
            req_wdata_i[k*DW +: DW] = DATA[k];
            req_wstrb_i[k*SW +: SW] = STRB[k];
            req_wlen_i[k*LW +: LW]  = LEN[k];
        end
    endtask

    task automatic apply_reset();
        rst_ni       = 1'b0;
        req_wvalid_i = '0;
        m_wready_i   = 1'b0;
        m_wlast_i    = 1'b0;
        set_payload();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        set_payload();
        req_wvalid_i = 4'hF;
        m_wready_i   = 1'b1;
        m_wlast_i    = 1'b0;
        step();
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o, m_wvalid_o, req_wready_o, req_wlast_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b grant=%0d mvalid=%b ready=%b last=%b expected all 0",
                     busy_o, grant_idx_o, m_wvalid_o, req_wready_o, req_wlast_o);
        end
        n_checks++;
        if ({m_waddr_o, m_wdata_o, m_wstrb_o, m_wlen_o} !== 76'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h data=%h strb=%h len=%h expected all 0",
                     m_waddr_o, m_wdata_o, m_wstrb_o, m_wlen_o);
        end
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_00) begin
            n_fail++;
            $display("FAIL reset_first_winner: got busy=%b grant=%0d expected busy=1 grant=0", busy_o, grant_idx_o);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] exp_data;
        apply_reset();
        req_waddr_i[1*AW +: AW] = 32'h0000_0100;
        req_wlen_i[1*LW +: LW]  = 8'd16;
        req_wvalid_i = 4'b0010;
        m_wready_i   = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, m_wvalid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_req_cycle: got busy=%b mvalid=%b expected 0 0", busy_o, m_wvalid_o);
        end
        step();
        for (int b = 0; b < 4; b++) begin
            exp_data = 32'hA000_0000 + 32'(b);
            req_wdata_i[1*DW +: DW] = exp_data;
            m_wlast_i = (b == 3);
            @(negedge clk_i);
            n_checks++;
            if ({busy_o, m_wvalid_o, grant_idx_o} !== 4'b11_01) begin
                n_fail++;
                $display("FAIL single_beat%0d_ctrl: got busy=%b mvalid=%b grant=%0d expected 1 1 1",
                         b, busy_o, m_wvalid_o, grant_idx_o);
            end
            n_checks++;
            if (m_waddr_o !== 32'h100 || m_wlen_o !== 8'd16 || m_wdata_o !== exp_data || m_wstrb_o !== 4'h3) begin
                n_fail++;
                $display("FAIL single_beat%0d_data: got addr=%h len=%0d data=%h strb=%h expected 00000100 16 %h 3",
                         b, m_waddr_o, m_wlen_o, m_wdata_o, m_wstrb_o, exp_data);
            end
            n_checks++;
            if (req_wready_o !== 4'b0010 || req_wlast_o !== ((b == 3) ? 4'b0010 : 4'b0000)) begin
                n_fail++;
                $display("FAIL single_beat%0d_rdy_last: got ready=%b last=%b expected ready=0010 last=%b",
                         b, req_wready_o, req_wlast_o, (b == 3) ? 4'b0010 : 4'b0000);
            end
            step();
        end
        m_wlast_i    = 1'b0;
        req_wvalid_i = '0;
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, m_wvalid_o, grant_idx_o} !== 4'b00_01) begin
            n_fail++;
            $display("FAIL single_release: got busy=%b mvalid=%b grant=%0d expected 0 0 1", busy_o, m_wvalid_o, grant_idx_o);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int g;
        apply_reset();
        req_wvalid_i = 4'hF;
        m_wready_i   = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_wvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_initial_idle: got mvalid=%b expected 0", m_wvalid_o);
        end
        step();
        for (int n = 0; n < 5; n++) begin
            g = order[n];
            m_wlast_i = 1'b0;
            @(negedge clk_i);
            n_checks++;
            if (grant_idx_o !== IW'(g) || m_wvalid_o !== 1'b1 || m_waddr_o !== ADDR[g]) begin
                n_fail++;
                $display("FAIL rr_xfer%0d_grant: got grant=%0d mvalid=%b addr=%h expected grant=%0d mvalid=1 addr=%h",
                         n, grant_idx_o, m_wvalid_o, m_waddr_o, g, ADDR[g]);
            end
            step();
            m_wlast_i = 1'b1;
            @(negedge clk_i);
            n_checks++;
            if (req_wlast_o !== 4'(1 << g)) begin
                n_fail++;
                $display("FAIL rr_xfer%0d_last: got last=%b expected %b", n, req_wlast_o, 4'(1 << g));
            end
            step();
            m_wlast_i = 1'b0;
            @(negedge clk_i);
            n_checks++;
            if ({busy_o, m_wvalid_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_gap%0d: got busy=%b mvalid=%b expected 0 0", n, busy_o, m_wvalid_o);
            end
            step();
        end
    endtask

    task automatic test_valid_gap();
        apply_reset();
        req_wvalid_i = 4'b0100;
        m_wready_i   = 1'b1;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({grant_idx_o, m_wvalid_o} !== 3'b10_1) begin
            n_fail++;
            $display("FAIL gap_start: got grant=%0d mvalid=%b expected 2 1", grant_idx_o, m_wvalid_o);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            req_wvalid_i = 4'b1001;
            @(negedge clk_i);
            n_checks++;
            if ({busy_o, grant_idx_o, m_wvalid_o, req_wready_o, req_wlast_o} !== {1'b1, 2'd2, 1'b0, 4'b0100, 4'b0000}) begin
                n_fail++;
                $display("FAIL gap_hold%0d: got busy=%b grant=%0d mvalid=%b ready=%b last=%b expected 1 2 0 0100 0000",
                         c, busy_o, grant_idx_o, m_wvalid_o, req_wready_o, req_wlast_o);
            end
            step();
        end
        req_wvalid_i = 4'b1101;
        m_wlast_i    = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_wvalid_o !== 1'b1 || req_wlast_o !== 4'b0100 || m_waddr_o !== ADDR[2]) begin
            n_fail++;
            $display("FAIL gap_resume: got mvalid=%b last=%b addr=%h expected 1 0100 %h",
                     m_wvalid_o, req_wlast_o, m_waddr_o, ADDR[2]);
        end
        step();
        m_wlast_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_release: got busy=%b expected 0", busy_o);
        end
        step();
        @(negedge clk_i);
        n_checks++;
        if (grant_idx_o !== NEXT_AFTER_GAP) begin
            n_fail++;
            $display("FAIL gap_next_owner: got grant=%0d expected %0d", grant_idx_o, NEXT_AFTER_GAP);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req_wvalid_i = 4'b1000;
        m_wready_i   = 1'b1;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_11) begin
            n_fail++;
            $display("FAIL simul_own3: got busy=%b grant=%0d expected 1 3", busy_o, grant_idx_o);
        end
        step();
        req_wvalid_i = 4'b1001;
        m_wlast_i    = 1'b1;
        step();
        m_wlast_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, m_wvalid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_idle: got busy=%b mvalid=%b expected 0 0", busy_o, m_wvalid_o);
        end
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_00) begin
            n_fail++;
            $display("FAIL simul_next0: got busy=%b grant=%0d expected 1 0", busy_o, grant_idx_o);
        end
        m_wlast_i = 1'b1;
        step();
        m_wlast_i = 1'b0;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_11) begin
            n_fail++;
            $display("FAIL simul_then3: got busy=%b grant=%0d expected 1 3", busy_o, grant_idx_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_wvalid_i = 4'b0100;
        m_wready_i   = 1'b1;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_10) begin
            n_fail++;
            $display("FAIL rstmid_own2: got busy=%b grant=%0d expected 1 2", busy_o, grant_idx_o);
        end
        step();
        req_wvalid_i = 4'b0110;
        rst_ni       = 1'b0;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o, m_wvalid_o, req_wready_o, req_wlast_o, m_waddr_o} !== 44'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got busy=%b grant=%0d mvalid=%b ready=%b last=%b addr=%h expected all 0",
                     busy_o, grant_idx_o, m_wvalid_o, req_wready_o, req_wlast_o, m_waddr_o);
        end
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_01) begin
            n_fail++;
            $display("FAIL rstmid_lowest: got busy=%b grant=%0d expected 1 1", busy_o, grant_idx_o);
        end
    endtask

`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        apply_reset();
        req_wvalid_i = 4'b0101;
        m_wready_i   = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            m_wlast_i = 1'b1;
            @(negedge clk_i);
            n_checks++;
            if ({busy_o, grant_idx_o} !== 3'b1_00) begin
                n_fail++;
                $display("FAIL fixed_xfer%0d: got busy=%b grant=%0d expected 1 0", n, busy_o, grant_idx_o);
            end
            step();
            m_wlast_i = 1'b0;
        end
        req_wvalid_i = 4'b0100;
        step();
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, grant_idx_o} !== 3'b1_10) begin
            n_fail++;
            $display("FAIL fixed_req2_after_drop: got busy=%b grant=%0d expected 1 2", busy_o, grant_idx_o);
        end
    endtask
`endif

    initial begin
        rst_ni       = 1'b0;
        req_wvalid_i = '0;
        req_waddr_i  = '0;
        req_wdata_i  = '0;
        req_wstrb_i  = '0;
        req_wlen_i   = '0;
        m_wready_i   = 1'b0;
        m_wlast_i    = 1'b0;
        test_reset();
        test_single();
        test_valid_gap();
        test_reset_mid();
`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_simultaneous();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_axi_write_arbiter.md
Name: simple_axi_write_arbiter

Overview:
- Shares one simple-AXI write port (valid/ready/addr/data/strb/len/last, byte-length transfers) among NUM_REQ requesters.
- Sits between the Versat write-side units and the single simple-to-AXI write bridge.
- Grants one requester at a time, round-robin, and holds the grant for a whole transfer until the bridge signals its final beat.
- Address and length are held by the owner for the full transfer, so the grant is never preempted.

Parameters:
- NUM_REQ, 4, number of requesters; valid range 2..16.
- AXI_ADDR_W, 32, address width.
- AXI_DATA_W, 32, data width; strobe width is AXI_DATA_W/8.
- LEN_W, 8, transfer length width, in bytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_wvalid_i  in  NUM_REQ  per-requester transfer/data valid.
- req_wready_o  out  NUM_REQ  per-requester data accept.
- req_waddr_i  in  NUM_REQ*AXI_ADDR_W  packed start addresses; requester k occupies slice k.
- req_wdata_i  in  NUM_REQ*AXI_DATA_W  packed data.
- req_wstrb_i  in  NUM_REQ*AXI_DATA_W/8  packed strobes.
- req_wlen_i  in  NUM_REQ*LEN_W  packed byte lengths.
- req_wlast_o  out  NUM_REQ  end of transfer, routed to the owner.
- m_wvalid_o  out  1  to bridge.
- m_wready_i  in  1  from bridge.
- m_waddr_o  out  AXI_ADDR_W  to bridge.
- m_wdata_o  out  AXI_DATA_W  to bridge.
- m_wstrb_o  out  AXI_DATA_W/8  to bridge.
- m_wlen_o  out  LEN_W  to bridge.
- m_wlast_i  in  1  final beat of the bridge transfer.
- busy_o  out  1  a grant is held.
- grant_idx_o  out  clog2(NUM_REQ)  current or last owner.

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - state=IDLE, grant_idx_o=0, busy_o=0, last_owner=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0.
  - Reset mid-transfer drops the grant immediately; the bridge must be reset with the same rst.
- IDLE:
  - m_wvalid_o=0, all req_wready_o=0, all req_wlast_o=0.
  - If any req_wvalid_i is high, pick the first set bit searching upward from last_owner+1, wrapping at NUM_REQ.
  - Register that index into grant_idx_o and set busy_o=1; go to GRANT.
  - Latency: a request seen in cycle t gives m_wvalid_o in cycle t+1.
- GRANT (owner g = grant_idx_o):
  - Outputs: m_wvalid_o=req_wvalid_i[g]; m_waddr/wdata/wstrb/wlen_o = slice g; req_wready_o[g]=m_wready_i.
  - All other ready and last bits are 0; all non-owner inputs are ignored.
  - Pass-through is combinational, with no pipeline stage.
  - req_wlast_o[g]=m_wlast_i.
  - Owner deasserting req_wvalid_i mid-transfer: the grant is kept, m_wvalid_o follows it low, and the arbiter does not time out.
  - When m_wlast_i=1: last_owner<=g, busy_o<=0, go to IDLE.
- Return to IDLE:
  - The mandatory IDLE cycle holds m_wvalid_o=0 for at least one cycle between transfers. The bridge needs this to return to its start state before sampling a new address and length.
  - Minimum spacing between transfer starts is transfer duration + 1 cycle.
- Simultaneous events:
  - m_wlast_i together with new requests: arbitration happens in the following IDLE cycle and uses the updated last_owner.
  - The previous owner is eligible again only after all other pending requesters.
- grant_idx_o holds its value in IDLE.
- Width rules: slice k spans bits [k*W +: W]; the index wraps modulo NUM_REQ without overflow (compare before increment).

Optional Feature:
- Macro SIMPLE_AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. last_owner is still tracked but ignored. A continuously requesting requester 0 starves the others; this is intended.
- Undefined (default): round-robin as described above.

Decomposition:
- Package simple_axi_arb_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - a clog2 function;
  - the IDX_W = max(1, clog2(NUM_REQ)) helper.
- Sub-module rr_picker: combinational.
  - Inputs: req vector, last_owner.
  - Outputs: valid and index.
  - Round-robin is built as a double-width rotated vector plus a priority encoder.
  - Contains the SIMPLE_AXI_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Single requester: req1 valid, addr 0x100, len 16, bridge model m_wready=1 → grant_idx=1 at cycle t+1; 4 beats pass through; req_wlast_o[1] is high on beat 4; busy drops the next cycle.
- All 4 requesting continuously, from reset → grant order 0,1,2,3,0. Each pair of transfers is separated by exactly one cycle with m_wvalid_o=0.
- Requester 2 deasserts valid for 3 cycles mid-burst → grant held; m_wvalid_o low for those 3 cycles; no other requester gets ready.
- m_wlast_i for owner 3 in the same cycle req0 and req3 both assert → next grant is 0; req3 is served after 0.
- Reset asserted in the middle of a GRANT transfer → next cycle busy_o=0, all outputs 0, and the first subsequent grant goes to the lowest pending index.
- With SIMPLE_AXI_ARB_FIXED_PRIO_EN defined, req0 and req2 requesting continuously → only 0 is ever granted; req2 is granted after req0 drops.
